mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences and shares the single-port unified instruction/data memory between three requesters: instruction fetch, CPU data load/store, and a program loader (test/boot write port).
- Sits between the CPU core and the unified memory array, so the core no longer relies on a fixed fetch/execute phase toggle.
- Runs one memory transaction at a time through a small FSM, with configurable read latency and a req/ack handshake per requester.

Parameters:
- ADDR_W, 30, word-address width (byte address bits [31:2])
- DATA_W, 32, data word width
- RD_LAT, 1, memory read latency in cycles from address valid to rdata valid; legal range 1..15

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-low
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  ADDR_W  fetch word address
- if_ack  out  1  one-cycle pulse; rdata valid this cycle
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle pulse; rdata valid this cycle for loads
- ld_req  in  1  loader write request; held until ld_ack
- ld_addr  in  ADDR_W  loader word address
- ld_wdata  in  DATA_W  loader write data
- ld_ack  out  1  one-cycle pulse, write done
- rdata  out  DATA_W  registered read data, shared by all requesters
- gnt_id  out  2  current owner: 0 none, 1 fetch, 2 data, 3 loader
- busy  out  1  high in any state other than IDLE
- mem_addr  out  ADDR_W  word address to memory
- mem_we  out  1  memory write enable
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (rst low at a clk edge):
  - State goes to IDLE.
  - All acks, busy, gnt_id, mem_we, mem_addr, mem_wdata and rdata are 0.
  - Latched transaction and round-robin pointer are cleared.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - If any request is high, pick the winner. Fixed priority: loader > data > fetch.
  - Latch the winner's address, write flag (loader always writes, fetch always reads) and write data.
  - Set gnt_id and go to ACCESS.
  - With no request, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_addr and mem_wdata are driven from the latched registers.
  - mem_we = latched write flag AND rst. mem_we is never high during a reset cycle.
  - Write: go to DONE.
  - Read with RD_LAT = 1: capture mem_rdata into rdata at the end of this cycle and go to DONE.
  - Read with RD_LAT > 1: go to WAIT with count = 1.
- WAIT:
  - mem_addr is held and mem_we is 0.
  - Count increments each cycle.
  - When count reaches RD_LAT-1, capture mem_rdata into rdata and go to DONE.
- DONE (1 cycle):
  - Pulse the owner's ack.
  - rdata holds until the next read capture.
  - Go to IDLE; gnt_id returns to 0 on the next cycle.
- Latency, counting the IDLE sampling cycle as cycle 0:
  - Read ack at cycle RD_LAT+1.
  - Write ack at cycle 2.
  - Minimum spacing between transactions is RD_LAT+2 cycles (reads) or 3 cycles (writes).
- Handshake rules:
  - Request inputs are sampled only in IDLE; address and data changes after sampling are ignored.
  - A requester that drops req mid-transaction still gets its transaction completed (a write is committed) and its ack pulsed.
  - A req still high in the IDLE cycle after DONE is treated as a new request.
  - At most one ack is high in any cycle.
- Boundary conditions:
  - Address arithmetic: none; addresses pass through unmodified, with no wrap or bounds check.
  - Reset low mid-transaction: the transaction is abandoned, no ack is issued, and a pending write is suppressed via the mem_we gating.
  - Simultaneous requests: resolved in IDLE only. Losers keep waiting without starving the loader.

Optional Feature:
- ARB_RR_EN defined:
  - A 1-bit last-served pointer arbitrates between data and fetch.
  - When both request in the same IDLE cycle, the one not served last wins.
  - The pointer updates on every data or fetch grant.
  - The loader stays highest priority.
- ARB_RR_EN undefined: fixed priority loader > data > fetch, and the pointer logic is absent.

Test Plan:
1. Hold rst low for 2 cycles with all req high → after reset: acks 0, mem_we 0, busy 0, gnt_id 0, rdata 0; first grant goes to the loader.
2. RD_LAT=1, memory word 5 = 0x24010000, if_req with if_addr=5 → mem_addr=5 at cycle 1, if_ack and rdata=0x24010000 at cycle 2, mem_we never high.
3. d_req, d_we=1, d_addr=3, d_wdata=0xDEADBEEF → mem_we high exactly 1 cycle with mem_addr=3, d_ack the next cycle; a following fetch of address 3 returns 0xDEADBEEF.
4. if_req and d_req raised together and held, then raised together again → fixed priority: data, fetch, data, fetch is not checked; instead check order data then fetch. With ARB_RR_EN, a second simultaneous pair after a data win is granted to fetch (gnt_id=1).
5. ld_req, d_req and if_req all high → gnt_id sequence 3, 2, 1, with exactly one ack per transaction.
6. RD_LAT=3 read → ack at cycle 4. Separately, rst driven low during the ACCESS cycle of a write → mem_we 0 that cycle, no ack, memory unchanged, FSM in IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port unified instruction/data memory between
// instruction fetch, CPU data load/store and the program loader. It runs one
// transaction at a time and uses a req/ack handshake for each requester.
//
// Build option:
//   ARB_RR_EN  When defined, data and fetch share a 1-bit last-served pointer.
//              When both request in the same IDLE cycle, the one not served
//              last wins. The loader always keeps top priority.
//              When undefined, priority is fixed: loader > data > fetch.
//
// Parameters:
//   ADDR_W  word-address width
//   DATA_W  data word width
//   RD_LAT  cycles from address valid to mem_rdata valid (legal range 1..15)
//
// Ports:
//   clk, rst                 clock; synchronous active-low reset
//   if_req/if_addr/if_ack    fetch requester (read only)
//   d_req/d_we/d_addr/d_wdata/d_ack   data requester (load or store)
//   ld_req/ld_addr/ld_wdata/ld_ack    loader requester (write only)
//   rdata                    registered read data, shared by all requesters
//   gnt_id                   current owner: 0 none, 1 fetch, 2 data, 3 loader
//   busy                     high whenever the FSM is not in IDLE
//   mem_addr/mem_we/mem_wdata/mem_rdata   memory array interface
//
// state  | meaning
// IDLE   | no owner; requests are sampled and arbitrated here only
// ACCESS | address/data presented for one cycle; write strobe if storing
// WAIT   | read in flight; count runs up to RD_LAT-1
// DONE   | owner's ack pulses; gnt_id clears on the way back to IDLE
module mem_arbiter #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        gnt_id,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_IF   = 2'd1;
    localparam logic [1:0] GNT_D    = 2'd2;
    localparam logic [1:0] GNT_LD   = 2'd3;
    localparam logic [3:0] LAT_LAST = 4'(RD_LAT - 1);

    state_t            state_q, state_d;
    logic [1:0]        gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [2:0]        ack_q, ack_d;      // {ld, d, if}
    logic              busy_q, busy_d;
    logic              pick_data;
    logic [2:0]        owner_ack;

`ifdef ARB_RR_EN
    logic rr_data_last_q, rr_data_last_d;   // 1: data was the last of data/fetch served

    assign pick_data = d_req && !(if_req && rr_data_last_q);
`else
    assign pick_data = d_req;
`endif

    assign owner_ack = {gnt_q == GNT_LD, gnt_q == GNT_D, gnt_q == GNT_IF};

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        ack_d   = 3'b000;
`ifdef ARB_RR_EN
        rr_data_last_d = rr_data_last_q;
`endif
        case (state_q)
            IDLE: begin
                if (ld_req) begin
                    gnt_d   = GNT_LD;
                    we_d    = 1'b1;
                    addr_d  = ld_addr;
                    wdata_d = ld_wdata;
                    state_d = ACCESS;
                end else if (pick_data) begin
                    gnt_d   = GNT_D;
                    we_d    = d_we;
                    addr_d  = d_addr;
                    wdata_d = d_wdata;
                    state_d = ACCESS;
`ifdef ARB_RR_EN
                    rr_data_last_d = 1'b1;
`endif
                end else if (if_req) begin
                    gnt_d   = GNT_IF;
                    we_d    = 1'b0;
                    addr_d  = if_addr;
                    wdata_d = '0;
                    state_d = ACCESS;
`ifdef ARB_RR_EN
                    rr_data_last_d = 1'b0;
`endif
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = DONE;
                    ack_d   = owner_ack;
                end else if (RD_LAT == 1) begin
                    rdata_d = mem_rdata;
                    state_d = DONE;
                    ack_d   = owner_ack;
                end else begin
                    cnt_d   = 4'd1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == LAT_LAST) begin
                    rdata_d = mem_rdata;
                    state_d = DONE;
                    ack_d   = owner_ack;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                gnt_d   = GNT_NONE;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= GNT_NONE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= 4'd0;
            ack_q   <= 3'b000;
            busy_q  <= 1'b0;
`ifdef ARB_RR_EN
            rr_data_last_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
`ifdef ARB_RR_EN
            rr_data_last_q <= rr_data_last_d;
`endif
        end
    end

    // rst gates the strobe combinationally so a write caught by reset in its
    // ACCESS cycle never reaches the array.
    assign mem_we    = we_q && (state_q == ACCESS) && rst;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign gnt_id    = gnt_q;
    assign busy      = busy_q;
    assign if_ack    = ack_q[0];
    assign d_ack     = ack_q[1];
    assign ld_ack    = ack_q[2];

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
`ifdef ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          if_req, d_req, d_we, ld_req;
    logic [AW-1:0] if_addr, d_addr, ld_addr;
    logic [DW-1:0] d_wdata, ld_wdata;
    logic          if_ack, d_ack, ld_ack, busy, mem_we;
    logic [DW-1:0] rdata, mem_wdata, mem_rdata;
    logic [1:0]    gnt_id;
    logic [AW-1:0] mem_addr;

    logic          if3_req;
    logic [AW-1:0] if3_addr;
    logic          if3_ack, d3_ack, ld3_ack, busy3, mem3_we;
    logic [DW-1:0] rdata3, mem3_wdata, mem3_rdata;
    logic [1:0]    gnt3;
    logic [AW-1:0] mem3_addr;

    logic [DW-1:0] mem [0:63];
    logic [DW-1:0] mem3 [0:63];
    logic [DW-1:0] model_mem [0:63];
    logic          bd_we;
    logic [5:0]    bd_addr;
    logic [DW-1:0] bd_data;

    int total = 0;
    int bad = 0;
    int ack_order[$];
    int gnt_seq[$];
    int multi_ack;
    int drain_to;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT_A)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
        .rdata(rdata), .gnt_id(gnt_id), .busy(busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT_B)) dut3 (
        .clk(clk), .rst(rst),
        .if_req(if3_req), .if_addr(if3_addr), .if_ack(if3_ack),
        .d_req(1'b0), .d_we(1'b0), .d_addr('0), .d_wdata('0), .d_ack(d3_ack),
        .ld_req(1'b0), .ld_addr('0), .ld_wdata('0), .ld_ack(ld3_ack),
        .rdata(rdata3), .gnt_id(gnt3), .busy(busy3),
        .mem_addr(mem3_addr), .mem_we(mem3_we), .mem_wdata(mem3_wdata), .mem_rdata(mem3_rdata)
    );

    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr]  <= bd_data;
            mem3[bd_addr] <= bd_data;
        end else begin
            if (mem_we)  mem[mem_addr[5:0]]   <= mem_wdata;
            if (mem3_we) mem3[mem3_addr[5:0]] <= mem3_wdata;
        end
    end
    assign mem_rdata  = mem[mem_addr[5:0]];
    assign mem3_rdata = mem3[mem3_addr[5:0]];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bd_write(input logic [5:0] a, input logic [DW-1:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        model_mem[a] = d;
        tick();
        bd_we = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        logic [1:0] prev;
        prev = 2'd0;
        ack_order.delete(); gnt_seq.delete();
        multi_ack = 0; drain_to = 0;
        for (int n = 0; n < max_cyc; n++) begin
            tick();
            if (gnt_id != 2'd0 && prev == 2'd0) gnt_seq.push_back(int'(gnt_id));
            prev = gnt_id;
            if ($countones({ld_ack, d_ack, if_ack}) > 1) multi_ack++;
            if (ld_ack) begin ack_order.push_back(3); ld_req = 1'b0; end
            if (d_ack)  begin ack_order.push_back(2); d_req  = 1'b0; end
            if (if_ack) begin ack_order.push_back(1); if_req = 1'b0; end
            if (!ld_req && !d_req && !if_req && !busy) return;
        end
        drain_to = 1;
    endtask

    task automatic drive(input int i, input logic p, input logic [AW-1:0] a,
                         input logic w, input logic [DW-1:0] wd);
        case (i)
            0: begin if_req = p; if_addr = a; end
            1: begin d_req = p; d_addr = a; d_we = w; d_wdata = wd; end
            default: begin ld_req = p; ld_addr = a; ld_wdata = wd; end
        endcase
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 64; i++) bd_write(6'(i), $urandom());
        ld_req = 1'b1; ld_addr = 30'd10; ld_wdata = 32'hCAFE_0010;
        d_req = 1'b1; d_we = 1'b0; d_addr = 30'd11;
        if_req = 1'b1; if_addr = 30'd12;
        tick(); tick();
        total++; if ({ld_ack, d_ack, if_ack} !== 3'b000) begin bad++; $display("FAIL rst_acks got=%b want=000", {ld_ack, d_ack, if_ack}); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b want=0", mem_we); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (gnt_id !== 2'd0) begin bad++; $display("FAIL rst_gnt got=%0d want=0", gnt_id); end
        total++; if (rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata got=%h want=0", rdata); end
        total++; if (mem_addr !== 30'd0 || mem_wdata !== 32'd0) begin bad++; $display("FAIL rst_mem_bus got=%h/%h want=0/0", mem_addr, mem_wdata); end
        rst = 1'b1;
        tick();
        total++; if (gnt_id !== 2'd3) begin bad++; $display("FAIL rst_first_gnt got=%0d want=3", gnt_id); end
        total++; if (mem_we !== 1'b1 || mem_addr !== 30'd10) begin bad++; $display("FAIL rst_first_write got=%b@%0d want=1@10", mem_we, mem_addr); end
        drain(40);
        total++; if (drain_to !== 0) begin bad++; $display("FAIL rst_drain_timeout got=%0d want=0", drain_to); end
        total++; if (multi_ack !== 0) begin bad++; $display("FAIL rst_multi_ack got=%0d want=0", multi_ack); end
        total++; if (ack_order.size() !== 3 || ack_order[0] !== 3 || ack_order[1] !== 2 || ack_order[2] !== 1)
            begin bad++; $display("FAIL rst_ack_order got=%p want=3,2,1", ack_order); end
        total++; if (gnt_seq.size() !== 3 || gnt_seq[0] !== 3 || gnt_seq[1] !== 2 || gnt_seq[2] !== 1)
            begin bad++; $display("FAIL rst_gnt_seq got=%p want=3,2,1", gnt_seq); end
    endtask

    task automatic test_fetch();
        bd_write(6'd5, 32'h2401_0000);
        if_req = 1'b1; if_addr = 30'd5;
        tick();
        total++; if (mem_addr !== 30'd5 || gnt_id !== 2'd1) begin bad++; $display("FAIL fetch_access got=addr%0d gnt%0d want=addr5 gnt1", mem_addr, gnt_id); end
        total++; if (mem_we !== 1'b0 || if_ack !== 1'b0) begin bad++; $display("FAIL fetch_c1 got=we%b ack%b want=we0 ack0", mem_we, if_ack); end
        if_addr = 30'd7;
        tick();
        total++; if (if_ack !== 1'b1) begin bad++; $display("FAIL fetch_ack got=%b want=1", if_ack); end
        total++; if (rdata !== 32'h2401_0000) begin bad++; $display("FAIL fetch_rdata got=%h want=24010000", rdata); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL fetch_c2_we got=%b want=0", mem_we); end
        if_req = 1'b0;
        tick();
        total++; if (if_ack !== 1'b0 || gnt_id !== 2'd0 || busy !== 1'b0) begin bad++; $display("FAIL fetch_c3 got=ack%b gnt%0d busy%b want=0/0/0", if_ack, gnt_id, busy); end
    endtask

    task automatic test_store_fetch();
        bd_write(6'd3, 32'd0);
        d_req = 1'b1; d_we = 1'b1; d_addr = 30'd3; d_wdata = 32'hDEAD_BEEF;
        tick();
        total++; if (mem_we !== 1'b1 || mem_addr !== 30'd3 || mem_wdata !== 32'hDEAD_BEEF)
            begin bad++; $display("FAIL store_access got=we%b addr%0d data%h want=we1 addr3 dataDEADBEEF", mem_we, mem_addr, mem_wdata); end
        total++; if (d_ack !== 1'b0) begin bad++; $display("FAIL store_early_ack got=%b want=0", d_ack); end
        d_wdata = 32'h0;
        tick();
        total++; if (mem_we !== 1'b0 || d_ack !== 1'b1) begin bad++; $display("FAIL store_done got=we%b ack%b want=we0 ack1", mem_we, d_ack); end
        d_req = 1'b0; d_we = 1'b0; if_req = 1'b1; if_addr = 30'd3;
        tick(); tick(); tick();
        total++; if (if_ack !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL store_readback got=ack%b %h want=ack1 DEADBEEF", if_ack, rdata); end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_pair();
        logic [1:0] exp_gnt;
        bd_write(6'd20, 32'h0000_AAAA);
        bd_write(6'd21, 32'h0000_BBBB);
        if_req = 1'b1; if_addr = 30'd20;
        d_req = 1'b1; d_we = 1'b0; d_addr = 30'd21;
        drain(30);
        total++; if (drain_to !== 0 || ack_order.size() !== 2 || ack_order[0] !== 2 || ack_order[1] !== 1)
            begin bad++; $display("FAIL pair_order got=%p to=%0d want=2,1", ack_order, drain_to); end
        d_req = 1'b1; d_addr = 30'd21;
        tick(); tick();
        total++; if (d_ack !== 1'b1 || rdata !== 32'h0000_BBBB) begin bad++; $display("FAIL pair_solo got=ack%b %h want=ack1 0000BBBB", d_ack, rdata); end
        // d_req stays high through DONE and counts as a fresh request
        if_req = 1'b1;
        tick(); tick();
        exp_gnt = RR_MODE ? 2'd1 : 2'd2;
        total++; if (gnt_id !== exp_gnt) begin bad++; $display("FAIL pair_second_gnt got=%0d want=%0d", gnt_id, exp_gnt); end
        drain(30);
        total++; if (drain_to !== 0 || multi_ack !== 0) begin bad++; $display("FAIL pair_drain got=to%0d multi%0d want=0/0", drain_to, multi_ack); end
    endtask

    task automatic test_three_way();
        int exp_mid;
        // after test_pair the RR pointer last served data, so fetch goes first
        exp_mid = RR_MODE ? 1 : 2;
        ld_req = 1'b1; ld_addr = 30'd40; ld_wdata = 32'h1234_0040;
        d_req = 1'b1; d_we = 1'b0; d_addr = 30'd41;
        if_req = 1'b1; if_addr = 30'd42;
        drain(40);
        total++; if (gnt_seq.size() !== 3 || gnt_seq[0] !== 3 || gnt_seq[1] !== exp_mid || gnt_seq[2] !== 3 - exp_mid)
            begin bad++; $display("FAIL three_gnt_seq got=%p want=3,%0d,%0d", gnt_seq, exp_mid, 3 - exp_mid); end
        total++; if (ack_order.size() !== 3 || multi_ack !== 0 || drain_to !== 0)
            begin bad++; $display("FAIL three_acks got=n%0d multi%0d to%0d want=3/0/0", ack_order.size(), multi_ack, drain_to); end
        total++; if (mem[40] !== 32'h1234_0040) begin bad++; $display("FAIL three_ld_write got=%h want=12340040", mem[40]); end
    endtask

    task automatic test_lat3();
        int first_ack, n_ack;
        logic [DW-1:0] got;
        bd_write(6'd5, 32'h5A5A_0005);
        first_ack = -1; n_ack = 0; got = '0;
        if3_req = 1'b1; if3_addr = 30'd5;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) begin
                total++; if (mem3_addr !== 30'd5 || busy3 !== 1'b1) begin bad++; $display("FAIL lat3_access got=addr%0d busy%b want=addr5 busy1", mem3_addr, busy3); end
            end
            if (if3_ack) begin
                n_ack++;
                if (first_ack < 0) begin first_ack = c; got = rdata3; if3_req = 1'b0; end
            end
        end
        total++; if (first_ack !== 4) begin bad++; $display("FAIL lat3_ack_cycle got=%0d want=4", first_ack); end
        total++; if (got !== 32'h5A5A_0005 || n_ack !== 1) begin bad++; $display("FAIL lat3_data got=%h n%0d want=5A5A0005 n1", got, n_ack); end
    endtask

    task automatic test_reset_mid_write();
        int acks_seen;
        bd_write(6'd9, 32'hA5A5_A5A5);
        d_req = 1'b1; d_we = 1'b1; d_addr = 30'd9; d_wdata = 32'h1234_5678;
        tick();
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL midrst_pre_we got=%b want=1", mem_we); end
        rst = 1'b0;
        #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL midrst_we_gated got=%b want=0", mem_we); end
        tick();
        d_req = 1'b0; d_we = 1'b0; rst = 1'b1;
        total++; if (busy !== 1'b0 || gnt_id !== 2'd0 || d_ack !== 1'b0)
            begin bad++; $display("FAIL midrst_idle got=busy%b gnt%0d ack%b want=0/0/0", busy, gnt_id, d_ack); end
        acks_seen = 0;
        for (int n = 0; n < 4; n++) begin
            tick();
            if (ld_ack || d_ack || if_ack) acks_seen++;
        end
        total++; if (acks_seen !== 0) begin bad++; $display("FAIL midrst_no_ack got=%0d want=0", acks_seen); end
        total++; if (mem[9] !== 32'hA5A5_A5A5) begin bad++; $display("FAIL midrst_mem got=%h want=A5A5A5A5", mem[9]); end
    endtask

    task automatic test_random();
        logic          pend [3];
        logic [AW-1:0] ra [3];
        logic          rw [3];
        logic [DW-1:0] rwd [3];
        int owner, grant_cyc, ack_cyc, next_free, done_cnt, win;
        logic          x_we, exp_busy, exp_we;
        logic [AW-1:0] x_addr;
        logic [DW-1:0] x_wd, x_rd;
        logic [2:0]    exp_ack;
        logic [1:0]    exp_gnt;
        bit            rr_data_last;
        for (int i = 0; i < 64; i++) bd_write(6'(i), $urandom());
        for (int i = 0; i < 3; i++) begin pend[i] = 1'b0; ra[i] = '0; rw[i] = 1'b0; rwd[i] = '0; end
        owner = -1; grant_cyc = 0; ack_cyc = 0; next_free = 0; done_cnt = 0;
        x_we = 1'b0; x_addr = '0; x_wd = '0; x_rd = '0; rr_data_last = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            exp_busy = (owner >= 0) && (c > grant_cyc);
            exp_we   = (owner >= 0) && x_we && (c == grant_cyc + 1);
            exp_ack  = (owner >= 0 && c == ack_cyc) ? 3'(1 << owner) : 3'b000;
            exp_gnt  = exp_busy ? 2'(owner + 1) : 2'd0;
            total++; if ({ld_ack, d_ack, if_ack} !== exp_ack) begin bad++; $display("FAIL rnd_ack c=%0d got=%b want=%b", c, {ld_ack, d_ack, if_ack}, exp_ack); end
            total++; if (busy !== exp_busy) begin bad++; $display("FAIL rnd_busy c=%0d got=%b want=%b", c, busy, exp_busy); end
            total++; if (mem_we !== exp_we) begin bad++; $display("FAIL rnd_mem_we c=%0d got=%b want=%b", c, mem_we, exp_we); end
            total++; if (gnt_id !== exp_gnt) begin bad++; $display("FAIL rnd_gnt c=%0d got=%0d want=%0d", c, gnt_id, exp_gnt); end
            if (owner >= 0 && c == grant_cyc + 1) begin
                total++; if (mem_addr !== x_addr || (x_we && mem_wdata !== x_wd))
                    begin bad++; $display("FAIL rnd_bus c=%0d got=%h/%h want=%h/%h", c, mem_addr, mem_wdata, x_addr, x_wd); end
            end
            if (owner >= 0 && c == ack_cyc) begin
                if (!x_we) begin
                    total++; if (rdata !== x_rd) begin bad++; $display("FAIL rnd_rdata c=%0d got=%h want=%h", c, rdata, x_rd); end
                end
                pend[owner] = 1'b0;
                drive(owner, 1'b0, ra[owner], rw[owner], rwd[owner]);
                owner = -1;
                done_cnt++;
            end
            // in-flight requester wiggles its address/data; already latched, must be ignored
            if (owner >= 0 && c > grant_cyc && $urandom_range(0, 1) == 0) begin
                ra[owner] = AW'($urandom()); rwd[owner] = $urandom();
                drive(owner, 1'b1, ra[owner], rw[owner], rwd[owner]);
            end
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(0, 3) == 0) begin
                    pend[i] = 1'b1;
                    ra[i]   = AW'($urandom());
                    rw[i]   = (i == 2) ? 1'b1 : (i == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                    rwd[i]  = $urandom();
                    drive(i, 1'b1, ra[i], rw[i], rwd[i]);
                end
            end
            if (owner < 0 && c >= next_free && (pend[0] || pend[1] || pend[2])) begin
                if (pend[2]) win = 2;
                else if (pend[1] && pend[0]) win = (RR_MODE && rr_data_last) ? 0 : 1;
                else if (pend[1]) win = 1;
                else win = 0;
                if (win == 1) rr_data_last = 1'b1;
                else if (win == 0) rr_data_last = 1'b0;
                owner = win; grant_cyc = c;
                x_we = rw[win]; x_addr = ra[win]; x_wd = rwd[win];
                ack_cyc = c + (x_we ? 2 : LAT_A + 1);
                if (x_we) model_mem[x_addr[5:0]] = x_wd;
                else x_rd = model_mem[x_addr[5:0]];
                next_free = ack_cyc + 1;
            end
            tick();
        end
        total++; if (done_cnt < 100) begin bad++; $display("FAIL rnd_throughput got=%0d want>=100", done_cnt); end
        if_req = 1'b0; d_req = 1'b0; ld_req = 1'b0;
        tick(); tick(); tick(); tick();
    endtask

    initial begin
        rst = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        ld_req = 1'b0; ld_addr = '0; ld_wdata = '0;
        if3_req = 1'b0; if3_addr = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        #1;
        test_reset();
        test_fetch();
        test_store_fetch();
        test_pair();
        test_three_way();
        test_lat3();
        test_reset_mid_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
